instruction_fetch_unit: RTL and testbench

- Fetch stage of the multicycle RISC processor: holds the PC, fetches from instruction memory, latches the instruction register (IR) and supplies the 4-bit opcode to the control unit.
- Consumes the control unit's `sigPCSrc`, `enIF` and a PC-write strobe to select the next PC.
- Sequential, taken-branch, jump (JMP/CALL) and return (RET) selection; RET is served by an internal return-address stack (RAS).

---
 rtl/instruction_fetch_unit_if.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control-unit strobes, instruction-memory port and fetch status.
// The master side (control unit + memory) drives strobes, targets and imemData.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W    = 16,
    parameter int INSTR_W   = 16,
    parameter int RAS_DEPTH = 8
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic                enIF;
    logic                pcWrite;
    logic [1:0]          sigPCSrc;
    logic                pushRet;
    logic [ADDR_W-1:0]   branchTarget;
    logic [ADDR_W-1:0]   jumpTarget;
    logic [ADDR_W-1:0]   imemAddr;
    logic [INSTR_W-1:0]  imemData;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pcPlus1;
    logic [INSTR_W-1:0]  instruction;
    logic [3:0]          instructionCode;
    logic [CNT_W-1:0]    rasCount;
    logic                rasOverflow;
    logic                rasUnderflow;
    logic [31:0]         fetchCount;
    logic [31:0]         redirectCount;

    modport master (
        output enIF, pcWrite, sigPCSrc, pushRet, branchTarget, jumpTarget, imemData,
        input  imemAddr, pc, pcPlus1, instruction, instructionCode,
        input  rasCount, rasOverflow, rasUnderflow, fetchCount, redirectCount
    );

    modport slave (
        input  enIF, pcWrite, sigPCSrc, pushRet, branchTarget, jumpTarget, imemData,
        output imemAddr, pc, pcPlus1, instruction, instructionCode,
        output rasCount, rasOverflow, rasUnderflow, fetchCount, redirectCount
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, IR latch, next-PC select and a circular return-address stack.
// Define FETCH_PERF_CNT_EN to build the fetch/redirect performance counters.
module instruction_fetch_unit #(
    parameter int              ADDR_W    = 16,
    parameter int              INSTR_W   = 16,
    parameter int              RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic                    clock,
    input logic                    reset,
    instruction_fetch_unit_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_RET    = 2'b11;

    logic [ADDR_W-1:0]  pcReg;
    logic [ADDR_W-1:0]  pcPlus1Reg;
    logic [INSTR_W-1:0] irReg;
    logic [ADDR_W-1:0]  seqAddr;
    logic [ADDR_W-1:0]  nextPc;
    logic [ADDR_W-1:0]  rasTopValue;
    logic [ADDR_W-1:0]  rasMem [RAS_DEPTH];
    logic [PTR_W-1:0]   topPtr;
    logic [PTR_W-1:0]   pushPtr;
    logic [CNT_W-1:0]   rasCnt;
    logic               ovfFlag;
    logic               unfFlag;
    logic               doPush;
    logic               doPop;
    logic               rasEmpty;
    logic               rasFull;

    always_comb begin
        seqAddr     = pcReg + ADDR_W'(1);
        doPush      = bus.pcWrite && (bus.sigPCSrc == SRC_JUMP) && bus.pushRet;
        doPop       = bus.pcWrite && (bus.sigPCSrc == SRC_RET);
        rasEmpty    = (rasCnt == '0);
        rasFull     = (rasCnt == RAS_FULL);
        pushPtr     = topPtr + PTR_W'(1);
        rasTopValue = rasMem[topPtr];
        nextPc      = seqAddr;
        unique case (bus.sigPCSrc)
            SRC_SEQ:    nextPc = seqAddr;
            SRC_BRANCH: nextPc = bus.branchTarget;
            SRC_JUMP:   nextPc = bus.jumpTarget;
            SRC_RET:    nextPc = rasEmpty ? seqAddr : rasTopValue;
            default:    nextPc = seqAddr;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcReg      <= RESET_PC;
            pcPlus1Reg <= RESET_PC + ADDR_W'(1);
            irReg      <= '0;
        end else begin
            if (bus.enIF) begin
                irReg      <= bus.imemData;
                pcPlus1Reg <= seqAddr;
            end
            if (bus.pcWrite) begin
                pcReg <= nextPc;
            end
        end
    end

    // A push when full lands on the oldest slot (top+1), so the count just saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            topPtr  <= '0;
            rasCnt  <= '0;
            ovfFlag <= 1'b0;
            unfFlag <= 1'b0;
        end else begin
            if (doPush) begin
                topPtr <= pushPtr;
                if (rasFull) begin
                    ovfFlag <= 1'b1;
                end else begin
                    rasCnt <= rasCnt + CNT_W'(1);
                end
            end else if (doPop) begin
                if (rasEmpty) begin
                    unfFlag <= 1'b1;
                end else begin
                    topPtr <= topPtr - PTR_W'(1);
                    rasCnt <= rasCnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            rasMem[pushPtr] <= seqAddr;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCnt;
    logic [31:0] redirectCnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetchCnt    <= '0;
            redirectCnt <= '0;
        end else begin
            if (bus.enIF) begin
                fetchCnt <= fetchCnt + 32'd1;
            end
            if (bus.pcWrite && (bus.sigPCSrc != SRC_SEQ)) begin
                redirectCnt <= redirectCnt + 32'd1;
            end
        end
    end

    assign bus.fetchCount    = fetchCnt;
    assign bus.redirectCount = redirectCnt;
`else
    assign bus.fetchCount    = '0;
    assign bus.redirectCount = '0;
`endif

    assign bus.imemAddr        = pcReg;
    assign bus.pc              = pcReg;
    assign bus.pcPlus1         = pcPlus1Reg;
    assign bus.instruction     = irReg;
    assign bus.instructionCode = irReg[INSTR_W-1 -: 4];
    assign bus.rasCount        = rasCnt;
    assign bus.rasOverflow     = ovfFlag;
    assign bus.rasUnderflow    = unfFlag;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a queue-based reference model
// predicts the architectural state after every edge; a monitor compares.
module tb_instruction_fetch_unit;
    localparam int ADDR_W    = 16;
    localparam int INSTR_W   = 16;
    localparam int RAS_DEPTH = 8;
    localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    instruction_fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:65535];
    assign bus.imemData = mem[bus.imemAddr];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] pcPlus1;
        logic [15:0] instr;
        logic [3:0]  rasCount;
        logic        ovf;
        logic        unf;
        logic [31:0] fc;
        logic [31:0] rc;
    } exp_t;

    exp_t sb[$];
    event checkNow;
    int tests = 0;
    int fails = 0;

    // Reference model: plain architectural state, return stack as a queue.
    logic [15:0] mPc, mPp1, mIr;
    logic [15:0] mRas[$];
    logic        mOvf, mUnf;
    logic [31:0] mFc, mRc;

    function automatic exp_t snap();
        exp_t e;
        e.pc       = mPc;
        e.pcPlus1  = mPp1;
        e.instr    = mIr;
        e.rasCount = 4'(mRas.size());
        e.ovf      = mOvf;
        e.unf      = mUnf;
        e.fc       = mFc;
        e.rc       = mRc;
        return e;
    endfunction

    task automatic modelReset();
        mPc  = RESET_PC;
        mPp1 = RESET_PC + 16'd1;
        mIr  = 16'h0000;
        mRas.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
        mFc  = 32'd0;
        mRc  = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t mon;
    always @(negedge clock or checkNow) begin
        while (sb.size() > 0) begin
            mon = sb.pop_front();
            chk("pc",              32'(bus.pc),              32'(mon.pc));
            chk("imemAddr",        32'(bus.imemAddr),        32'(mon.pc));
            chk("pcPlus1",         32'(bus.pcPlus1),         32'(mon.pcPlus1));
            chk("instruction",     32'(bus.instruction),     32'(mon.instr));
            chk("instructionCode", 32'(bus.instructionCode), 32'(mon.instr[15:12]));
            chk("rasCount",        32'(bus.rasCount),        32'(mon.rasCount));
            chk("rasOverflow",     32'(bus.rasOverflow),     32'(mon.ovf));
            chk("rasUnderflow",    32'(bus.rasUnderflow),    32'(mon.unf));
            chk("fetchCount",      bus.fetchCount,           mon.fc);
            chk("redirectCount",   bus.redirectCount,        mon.rc);
        end
    end

    task automatic step(input bit en, input bit pw, input logic [1:0] src, input bit push,
                        input logic [15:0] bt, input logic [15:0] jt);
        logic [15:0] seq;
        logic [15:0] npc;
        @(negedge clock);
        bus.enIF         = en;
        bus.pcWrite      = pw;
        bus.sigPCSrc     = src;
        bus.pushRet      = push;
        bus.branchTarget = bt;
        bus.jumpTarget   = jt;
        seq = mPc + 16'd1;
        npc = mPc;
        if (pw) begin
            case (src)
                2'd0: npc = seq;
                2'd1: npc = bt;
                2'd2: begin
                    npc = jt;
                    if (push) begin
                        mRas.push_back(seq);
                        if (mRas.size() > RAS_DEPTH) begin
                            void'(mRas.pop_front());
                            mOvf = 1'b1;
                        end
                    end
                end
                default: begin
                    if (mRas.size() > 0) npc = mRas.pop_back();
                    else begin
                        npc  = seq;
                        mUnf = 1'b1;
                    end
                end
            endcase
`ifdef FETCH_PERF_CNT_EN
            if (src != 2'd0) mRc = mRc + 32'd1;
`endif
        end
        if (en) begin
            mIr  = mem[mPc];
            mPp1 = seq;
`ifdef FETCH_PERF_CNT_EN
            mFc  = mFc + 32'd1;
`endif
        end
        mPc = npc;
        @(posedge clock);
        #1;
        sb.push_back(snap());
        bus.enIF    = 1'b0;
        bus.pcWrite = 1'b0;
        bus.pushRet = 1'b0;
    endtask

    task automatic jumpTo(input logic [15:0] a);
        step(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, a);
    endtask

    task automatic callTo(input logic [15:0] a);
        step(1'b0, 1'b1, 2'd2, 1'b1, 16'h0, a);
    endtask

    task automatic doRet();
        step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0);
    endtask

    // Reset lands between edges; the check fires before the next clock edge.
    task automatic asyncReset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        sb.push_back(snap());
        ->checkNow;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        sb.push_back(snap());
        ->checkNow;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        mem[2] = 16'h9ABC;
        bus.enIF = 1'b0; bus.pcWrite = 1'b0; bus.sigPCSrc = 2'd0; bus.pushRet = 1'b0;
        bus.branchTarget = 16'h0; bus.jumpTarget = 16'h0;
        modelReset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        sb.push_back(snap());
        ->checkNow;

        // Sequential fetch of 0x1234, 0x5678, 0x9ABC
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        chk("seq3_instruction", 32'(bus.instruction), 32'h9ABC);
        chk("seq3_pc", 32'(bus.pc), 32'h3);

        // Branch, then branch request without pcWrite
        jumpTo(16'h0010);
        step(1'b0, 1'b1, 2'd1, 1'b0, 16'h0040, 16'h0);
        step(1'b0, 1'b0, 2'd1, 1'b0, 16'h0080, 16'h0);

        // CALL/RET pair; pushRet without pcWrite or with other src is ignored
        jumpTo(16'h0005);
        callTo(16'h0100);
        step(1'b0, 1'b0, 2'd2, 1'b1, 16'h0, 16'h0200);
        step(1'b0, 1'b1, 2'd1, 1'b1, 16'h0300, 16'h0);
        doRet();
        doRet();

        // RAS overflow and underflow
        asyncReset();
        for (int i = 0; i < 9; i++) begin
            jumpTo(16'(i));
            callTo(16'h0800 + 16'(i));
        end
        for (int i = 0; i < 9; i++) doRet();

        // PC wrap
        jumpTo(16'hFFFF);
        step(1'b1, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0);

        // Randomised mix
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 16'($urandom), 16'($urandom));
            if (i == 200) asyncReset();
        end

        // Counter scenario from a clean reset
        asyncReset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 2'd1, 1'b0, 16'h0020, 16'h0);
        step(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, 16'h0030);
        @(negedge clock);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetchCount", bus.fetchCount, 32'd5);
        chk("perf_redirectCount", bus.redirectCount, 32'd2);
`else
        chk("perf_fetchCount", bus.fetchCount, 32'd0);
        chk("perf_redirectCount", bus.redirectCount, 32'd0);
`endif

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
